// File: rtl/func_lookup_engine.sv
// PC-to-function resolver: queued PCs, sequential binary search over an external sorted table.
// Optional FUNC_PROFILE_EN adds a saturating hit counter for one selectable function index.
module func_lookup_engine #(
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W:0]    tbl_count,
    input  logic              pc_valid,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_ready,
    output logic [IDX_W-1:0]  tbl_raddr,
    input  logic [ADDR_W-1:0] tbl_rdata,
    input  logic              res_ready,
`ifdef FUNC_PROFILE_EN
    input  logic [IDX_W-1:0]  prof_idx,
    input  logic              prof_clr,
    output logic [31:0]       prof_count,
`endif
    output logic              res_valid,
    output logic [IDX_W-1:0]  res_idx,
    output logic [ADDR_W-1:0] res_base,
    output logic              res_miss
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W:0] IDX_ONE = {{IDX_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_DONE} state_t;

    // ---------------- input PC queue ----------------
    logic [ADDR_W-1:0] r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic              w_push;
    logic              w_pop;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                          (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign pc_ready     = !w_fifo_full;
    assign w_push       = pc_valid && !w_fifo_full;

    // NOTE: storage arrays carry no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[PTR_W-1:0]] <= pc_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // ---------------- search engine ----------------
    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [IDX_W:0]    r_lo, w_lo_nxt;
    logic [IDX_W:0]    r_hi, w_hi_nxt;
    logic [IDX_W-1:0]  r_best, w_best_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic              r_found, w_found_nxt;
    logic [IDX_W-1:0]  r_raddr, w_raddr_nxt;
    logic              w_load;
    logic              w_stop;

    logic              r_res_valid;
    logic [IDX_W-1:0]  r_res_idx;
    logic [ADDR_W-1:0] r_res_base;
    logic              r_res_miss;
    logic              w_res_hs;
    logic              w_out_free;

    assign w_res_hs   = r_res_valid && res_ready;
    assign w_out_free = !r_res_valid || res_ready;

    // NOTE: every variable gets a default at the top so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_best_nxt  = r_best;
        w_base_nxt  = r_base;
        w_found_nxt = r_found;
        w_raddr_nxt = r_raddr;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_stop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty && w_out_free) begin
                    w_pop       = 1'b1;
                    w_pc_nxt    = r_fifo_mem[r_rd_ptr[PTR_W-1:0]];
                    w_lo_nxt    = '0;
                    w_hi_nxt    = tbl_count - IDX_ONE;
                    w_found_nxt = 1'b0;
                    w_best_nxt  = '0;
                    w_base_nxt  = '0;
                    if (tbl_count == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_raddr_nxt = IDX_W'(w_hi_nxt >> 1);
                        w_state_nxt = S_READ;
                    end
                end
            end
            S_READ: begin
                w_state_nxt = S_CMP;
            end
            S_CMP: begin
                // lo/hi are one bit wider than an index, so lo may reach 2**IDX_W safely
                if (tbl_rdata <= r_pc) begin
                    w_best_nxt  = r_raddr;
                    w_base_nxt  = tbl_rdata;
                    w_found_nxt = 1'b1;
                    w_lo_nxt    = {1'b0, r_raddr} + IDX_ONE;
                end else if (r_raddr == '0) begin
                    w_stop = 1'b1;
                end else begin
                    w_hi_nxt = {1'b0, r_raddr} - IDX_ONE;
                end
                if (!w_stop && (w_lo_nxt <= w_hi_nxt)) begin
                    w_raddr_nxt = IDX_W'((w_lo_nxt + w_hi_nxt) >> 1);
                    w_state_nxt = S_READ;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_load      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_best  <= '0;
            r_base  <= '0;
            r_found <= 1'b0;
            r_raddr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_best  <= w_best_nxt;
            r_base  <= w_base_nxt;
            r_found <= w_found_nxt;
            r_raddr <= w_raddr_nxt;
        end
    end

    // ---------------- result register ----------------
    // A search only starts when this register is free, so a load never collides with a held result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_base  <= '0;
            r_res_miss  <= 1'b0;
        end else if (w_load) begin
            r_res_valid <= 1'b1;
            r_res_idx   <= r_found ? r_best : '0;
            r_res_base  <= r_found ? r_base : '0;
            r_res_miss  <= !r_found;
        end else if (w_res_hs) begin
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_base  <= '0;
            r_res_miss  <= 1'b0;
        end
    end

    assign tbl_raddr = r_raddr;
    assign res_valid = r_res_valid;
    assign res_idx   = r_res_idx;
    assign res_base  = r_res_base;
    assign res_miss  = r_res_miss;

`ifdef FUNC_PROFILE_EN
    logic [31:0] r_prof_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prof_count <= '0;
        end else if (prof_clr) begin
            r_prof_count <= '0;
        end else if (w_res_hs && !r_res_miss && (r_res_idx == prof_idx) &&
                     (r_prof_count != 32'hFFFF_FFFF)) begin
            r_prof_count <= r_prof_count + 32'd1;
        end
    end

    assign prof_count = r_prof_count;
`endif

endmodule

// File: tb/tb_func_lookup_engine.sv
// Self-checking bench for func_lookup_engine: directed steps, result scoreboard, latency and probe checks.
// Profile-counter steps compile only when FUNC_PROFILE_EN is defined.
module tb_func_lookup_engine;

    localparam int ADDR_W     = 32;
    localparam int IDX_W      = 10;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [IDX_W:0]    tbl_count;
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_ready;
    logic [IDX_W-1:0]  tbl_raddr;
    logic [ADDR_W-1:0] tbl_rdata = '0;
    logic              res_ready;
    logic              res_valid;
    logic [IDX_W-1:0]  res_idx;
    logic [ADDR_W-1:0] res_base;
    logic              res_miss;
`ifdef FUNC_PROFILE_EN
    logic [IDX_W-1:0]  prof_idx;
    logic              prof_clr;
    logic [31:0]       prof_count;
`endif

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [ADDR_W-1:0] base;
        logic              miss;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_fail   = 0;
    int   n_res    = 0;
    int   n_exp    = 0;
    int   edge_cnt = 0;
    int   t_dummy;

    logic [ADDR_W-1:0] tbl_mem [0:(1<<IDX_W)-1];

    func_lookup_engine #(
        .ADDR_W(ADDR_W), .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tbl_count  (tbl_count),
        .pc_valid   (pc_valid),
        .pc_in      (pc_in),
        .pc_ready   (pc_ready),
        .tbl_raddr  (tbl_raddr),
        .tbl_rdata  (tbl_rdata),
        .res_ready  (res_ready),
`ifdef FUNC_PROFILE_EN
        .prof_idx   (prof_idx),
        .prof_clr   (prof_clr),
        .prof_count (prof_count),
`endif
        .res_valid  (res_valid),
        .res_idx    (res_idx),
        .res_base   (res_base),
        .res_miss   (res_miss)
    );

    always #5 clk = ~clk;

    // Synchronous table read port: data appears one cycle after the address.
    always @(posedge clk) begin
        edge_cnt  <= edge_cnt + 1;
        tbl_rdata <= tbl_mem[tbl_raddr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: linear scan for the greatest entry <= pc.
    function automatic exp_t model(input logic [ADDR_W-1:0] pc, input int cnt);
        exp_t r;
        r      = '0;
        r.miss = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            if (tbl_mem[i] <= pc) begin
                r.idx  = i[IDX_W-1:0];
                r.base = tbl_mem[i];
                r.miss = 1'b0;
            end
        end
        return r;
    endfunction

    // Result monitor: every handshake pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && res_valid && res_ready) begin
            n_res++;
            check("scoreboard_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check($sformatf("res_idx#%0d", n_res), 64'(res_idx), 64'(e.idx));
                check($sformatf("res_base#%0d", n_res), 64'(res_base), 64'(e.base));
                check($sformatf("res_miss#%0d", n_res), 64'(res_miss), 64'(e.miss));
            end
        end
    end

    task automatic push_pc(input logic [ADDR_W-1:0] pc, input bit track, output int t0);
        int k;
        @(negedge clk);
        pc_valid = 1'b1;
        pc_in    = pc;
        k        = 0;
        while (!pc_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("push_accept pc=%0h", pc), 64'(pc_ready), 64'd1);
        t0 = edge_cnt + 1;
        if (track) begin
            sb.push_back(model(pc, int'(tbl_count)));
            n_exp++;
        end
        @(posedge clk);
    endtask

    task automatic pc_idle();
        @(negedge clk);
        pc_valid = 1'b0;
    endtask

    task automatic set_res_ready(input logic v);
        @(posedge clk);
        #1 res_ready = v;
    endtask

    // One search on an idle engine: checks latency and the first np table addresses probed.
    task automatic search(input logic [ADDR_W-1:0] pc, input int exp_lat, input int np,
                          input int a0, input int a1, input int a2);
        int t0;
        int lat;
        int probes[$];
        int exp_a[3];
        exp_a[0] = a0;
        exp_a[1] = a1;
        exp_a[2] = a2;
        push_pc(pc, 1'b1, t0);
        @(negedge clk);
        pc_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (res_valid) begin
                lat = edge_cnt - t0;
                break;
            end
            if (((edge_cnt - t0) % 2) == 1) probes.push_back(int'(tbl_raddr));
            @(negedge clk);
        end
        check($sformatf("latency pc=%0h", pc), 64'(lat), 64'(exp_lat));
        for (int k = 0; k < np; k++) begin
            check($sformatf("probe%0d pc=%0h", k, pc),
                  (k < probes.size()) ? 64'(probes[k]) : 64'hDEAD, 64'(exp_a[k]));
        end
    endtask

    initial begin
        int t0;
        for (int i = 0; i < (1 << IDX_W); i++) tbl_mem[i] = 32'hFFFF_FFFF;
        tbl_mem[0] = 32'h100;
        tbl_mem[1] = 32'h200;
        tbl_mem[2] = 32'h300;
        tbl_mem[3] = 32'h400;
        reset     = 1'b1;
        tbl_count = 11'd4;
        pc_valid  = 1'b0;
        pc_in     = '0;
        res_ready = 1'b1;
`ifdef FUNC_PROFILE_EN
        prof_idx  = 10'd2;
        prof_clr  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst pc_ready",  64'(pc_ready),  64'd1);
        check("rst res_valid", 64'(res_valid), 64'd0);
        check("rst res_idx",   64'(res_idx),   64'd0);
        check("rst res_base",  64'(res_base),  64'd0);
        check("rst res_miss",  64'(res_miss),  64'd0);
        check("rst tbl_raddr", 64'(tbl_raddr), 64'd0);
`ifdef FUNC_PROFILE_EN
        check("rst prof_count", 64'(prof_count), 64'd0);
`endif
        reset = 1'b0;

        // Basic lookups: hit in middle, hit on last entry, below table.
        search(32'h250, 6, 2, 1, 2, 0);
        search(32'h400, 8, 3, 1, 2, 3);
        search(32'h080, 6, 2, 1, 0, 0);
        search(32'h100, 6, 2, 1, 0, 0);

        // Empty table: immediate miss, no probes.
        tbl_count = 11'd0;
        search(32'h300, 2, 0, 0, 0, 0);
        tbl_count = 11'd4;
        repeat (2) @(negedge clk);

        // Back-pressure: queue fills, then drains in order with nothing lost.
        set_res_ready(1'b0);
        push_pc(32'h150, 1'b1, t_dummy);
        push_pc(32'h250, 1'b1, t_dummy);
        push_pc(32'h350, 1'b1, t_dummy);
        push_pc(32'h450, 1'b1, t_dummy);
        push_pc(32'h110, 1'b1, t_dummy);
        pc_idle();
        repeat (10) @(negedge clk);
        check("bp pc_ready_full", 64'(pc_ready),  64'd0);
        check("bp res_held",      64'(res_valid), 64'd1);
        check("bp res_idx_held",  64'(res_idx),   64'd0);
        check("bp res_base_held", 64'(res_base),  64'h100);
        set_res_ready(1'b1);
        push_pc(32'h120, 1'b1, t_dummy);
        pc_idle();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        check("bp drained", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);

        // Reset during the first compare abandons the search and flushes the queue.
        push_pc(32'h350, 1'b0, t0);
        push_pc(32'h150, 1'b0, t_dummy);
        pc_idle();
        for (int i = 0; i < 20 && edge_cnt < t0 + 2; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst res_valid", 64'(res_valid), 64'd0);
        check("midrst pc_ready",  64'(pc_ready),  64'd1);
        check("midrst tbl_raddr", 64'(tbl_raddr), 64'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("midrst fifo_flushed", 64'(res_valid), 64'd0);
        search(32'h200, 6, 2, 1, 2, 0);

`ifdef FUNC_PROFILE_EN
        // Profiling: count hits on index 2 only.
        @(posedge clk);
        #1 prof_clr = 1'b1;
        @(posedge clk);
        #1 prof_clr = 1'b0;
        search(32'h300, 8, 3, 1, 2, 3);
        search(32'h3FF, 8, 3, 1, 2, 3);
        search(32'h080, 6, 2, 1, 0, 0);
        search(32'h200, 6, 2, 1, 2, 0);
        repeat (2) @(negedge clk);
        check("prof_count hits", 64'(prof_count), 64'd2);
        @(posedge clk);
        #1 prof_clr = 1'b1;
        @(posedge clk);
        #1 prof_clr = 1'b0;
        @(negedge clk);
        check("prof_count clr", 64'(prof_count), 64'd0);
`endif

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("final scoreboard empty", 64'(sb.size()), 64'd0);
        check("final result count", 64'(n_res), 64'(n_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
